// File: rtl/rs_mul_multi.sv
// Multiplier reservation station: ENT_NUM entries, two dispatch slots, WB_NUM-bus
// operand wakeup, and oldest-first issue chosen through an age matrix.
module rs_mul_multi #(
  parameter int ENT_NUM = 4,
  parameter int ENT_SEL = $clog2(ENT_NUM),
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int WB_NUM  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_flush,
  input  logic                      i_stall,
  input  logic                      i_dp_vld_1,
  input  logic                      i_dp_signed1_1,
  input  logic                      i_dp_signed2_1,
  input  logic                      i_dp_sel_high_1,
  input  logic                      i_dp_op1_vld_1,
  input  logic                      i_dp_op2_vld_1,
  input  logic [DATA_W-1:0]         i_dp_op1_1,
  input  logic [DATA_W-1:0]         i_dp_op2_1,
  input  logic [TAG_W-1:0]          i_dp_rrftag_1,
  input  logic                      i_dp_vld_2,
  input  logic                      i_dp_signed1_2,
  input  logic                      i_dp_signed2_2,
  input  logic                      i_dp_sel_high_2,
  input  logic                      i_dp_op1_vld_2,
  input  logic                      i_dp_op2_vld_2,
  input  logic [DATA_W-1:0]         i_dp_op1_2,
  input  logic [DATA_W-1:0]         i_dp_op2_2,
  input  logic [TAG_W-1:0]          i_dp_rrftag_2,
  input  logic [WB_NUM-1:0]         i_wb_vld,
  input  logic [WB_NUM*TAG_W-1:0]   i_wb_tag,
  input  logic [WB_NUM*DATA_W-1:0]  i_wb_data,
  output logic [ENT_SEL:0]          o_free_cnt,
  output logic [ENT_NUM-1:0]        o_busy_vec,
  output logic [ENT_NUM-1:0]        o_rdy_vec,
  output logic                      o_ovf,
  output logic                      o_is_vld,
  input  logic                      i_is_rdy,
  output logic                      o_is_signed1,
  output logic                      o_is_signed2,
  output logic                      o_is_sel_high,
  output logic [DATA_W-1:0]         o_is_op1,
  output logic [DATA_W-1:0]         o_is_op2,
  output logic [TAG_W-1:0]          o_is_rrftag
);

  // {hit, data}; lowest-numbered matching bus wins
  function automatic logic [DATA_W:0] wb_lookup(input logic [TAG_W-1:0] tag,
                                                input logic [WB_NUM-1:0] vld,
                                                input logic [WB_NUM*TAG_W-1:0] tags,
                                                input logic [WB_NUM*DATA_W-1:0] data);
    logic [DATA_W:0] res;
    res = '0;
    for (int b = WB_NUM - 1; b >= 0; b--)
      if (vld[b] && tags[b*TAG_W +: TAG_W] == tag) res = {1'b1, data[b*DATA_W +: DATA_W]};
    return res;
  endfunction

  // {found, index} of the lowest set bit
  function automatic logic [ENT_SEL:0] first_set(input logic [ENT_NUM-1:0] v);
    logic [ENT_SEL:0] res;
    res = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--)
      if (v[i]) res = {1'b1, ENT_SEL'(i)};
    return res;
  endfunction

  logic [ENT_NUM-1:0] r_busy, r_op1_vld, r_op2_vld;
  logic [ENT_NUM-1:0] r_signed1, r_signed2, r_sel_high;
  logic [DATA_W-1:0]  r_op1 [ENT_NUM];
  logic [DATA_W-1:0]  r_op2 [ENT_NUM];
  logic [TAG_W-1:0]   r_rrftag [ENT_NUM];
  logic [ENT_NUM-1:0] r_age [ENT_NUM];
  logic               r_ovf;

  logic [ENT_NUM-1:0] w_free2, w_rdy, w_sel, w_wk1, w_wk2;
  logic [DATA_W:0]    w_lk1 [ENT_NUM];
  logic [DATA_W:0]    w_lk2 [ENT_NUM];
  logic [ENT_NUM-1:0] w_age_nxt [ENT_NUM];
  logic [ENT_SEL-1:0] w_idx1, w_idx2, w_sel_idx;
  logic               w_found1, w_found2, w_sel_any;
  logic               w_we1, w_we2, w_wr1, w_wr2, w_drop, w_issue;
  logic [DATA_W:0]    w_byp11, w_byp12, w_byp21, w_byp22;
  logic [DATA_W-1:0]  w_op1_1, w_op2_1, w_op1_2, w_op2_2;
  logic [ENT_SEL:0]   w_busy_cnt;

  // Allocation from registered busy only; slot 2 skips slot 1's pick
  always_comb begin
    {w_found1, w_idx1} = first_set(~r_busy);
    w_free2 = ~r_busy;
    if (i_dp_vld_1 && w_found1) w_free2[w_idx1] = 1'b0;
    {w_found2, w_idx2} = first_set(w_free2);
    w_we1  = i_dp_vld_1 & ~i_stall & ~i_flush;
    w_we2  = i_dp_vld_2 & ~i_stall & ~i_flush;
    w_wr1  = w_we1 & w_found1;
    w_wr2  = w_we2 & w_found2;
    w_drop = (w_we1 & ~w_found1) | (w_we2 & ~w_found2);
  end

  // Dispatch-cycle bypass from live broadcast buses
  always_comb begin
    w_byp11 = wb_lookup(i_dp_op1_1[TAG_W-1:0], i_wb_vld, i_wb_tag, i_wb_data);
    w_byp21 = wb_lookup(i_dp_op2_1[TAG_W-1:0], i_wb_vld, i_wb_tag, i_wb_data);
    w_byp12 = wb_lookup(i_dp_op1_2[TAG_W-1:0], i_wb_vld, i_wb_tag, i_wb_data);
    w_byp22 = wb_lookup(i_dp_op2_2[TAG_W-1:0], i_wb_vld, i_wb_tag, i_wb_data);
    w_op1_1 = (!i_dp_op1_vld_1 && w_byp11[DATA_W]) ? w_byp11[DATA_W-1:0] : i_dp_op1_1;
    w_op2_1 = (!i_dp_op2_vld_1 && w_byp21[DATA_W]) ? w_byp21[DATA_W-1:0] : i_dp_op2_1;
    w_op1_2 = (!i_dp_op1_vld_2 && w_byp12[DATA_W]) ? w_byp12[DATA_W-1:0] : i_dp_op1_2;
    w_op2_2 = (!i_dp_op2_vld_2 && w_byp22[DATA_W]) ? w_byp22[DATA_W-1:0] : i_dp_op2_2;
  end

  always_comb begin
    for (int i = 0; i < ENT_NUM; i++) begin
      w_lk1[i] = wb_lookup(r_op1[i][TAG_W-1:0], i_wb_vld, i_wb_tag, i_wb_data);
      w_lk2[i] = wb_lookup(r_op2[i][TAG_W-1:0], i_wb_vld, i_wb_tag, i_wb_data);
      w_wk1[i] = r_busy[i] & ~r_op1_vld[i] & w_lk1[i][DATA_W];
      w_wk2[i] = r_busy[i] & ~r_op2_vld[i] & w_lk2[i][DATA_W];
    end
  end

  // An entry is selected when no other ready entry is older than it
  always_comb begin
    w_rdy = r_busy & r_op1_vld & r_op2_vld;
    for (int i = 0; i < ENT_NUM; i++) begin
      w_sel[i] = w_rdy[i];
      for (int j = 0; j < ENT_NUM; j++)
        if (j != i && w_rdy[j] && r_age[j][i]) w_sel[i] = 1'b0;
    end
    {w_sel_any, w_sel_idx} = first_set(w_sel);
    w_issue = w_sel_any & i_is_rdy;
  end

  always_comb begin
    for (int i = 0; i < ENT_NUM; i++) w_age_nxt[i] = r_age[i];
    if (w_wr1) begin
      w_age_nxt[w_idx1] = '0;
      for (int j = 0; j < ENT_NUM; j++) w_age_nxt[j][w_idx1] = r_busy[j];
    end
    if (w_wr2) begin
      w_age_nxt[w_idx2] = '0;
      for (int j = 0; j < ENT_NUM; j++)
        w_age_nxt[j][w_idx2] = r_busy[j] | (w_wr1 && ENT_SEL'(j) == w_idx1);
    end
  end

  always_comb begin
    w_busy_cnt = '0;
    for (int i = 0; i < ENT_NUM; i++) w_busy_cnt = w_busy_cnt + (ENT_SEL + 1)'(r_busy[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_op1_vld <= '0;
      r_op2_vld <= '0;
      r_ovf     <= 1'b0;
      for (int i = 0; i < ENT_NUM; i++) r_age[i] <= '0;
    end else begin
      r_ovf <= w_drop;
      for (int i = 0; i < ENT_NUM; i++) r_age[i] <= w_age_nxt[i];
      if (i_flush) begin
        r_busy <= '0;
      end else begin
        for (int i = 0; i < ENT_NUM; i++) begin
          if (w_wk1[i]) r_op1_vld[i] <= 1'b1;
          if (w_wk2[i]) r_op2_vld[i] <= 1'b1;
        end
        if (w_issue) r_busy[w_sel_idx] <= 1'b0;
        if (w_wr1) begin
          r_busy[w_idx1]    <= 1'b1;
          r_op1_vld[w_idx1] <= i_dp_op1_vld_1 | w_byp11[DATA_W];
          r_op2_vld[w_idx1] <= i_dp_op2_vld_1 | w_byp21[DATA_W];
        end
        if (w_wr2) begin
          r_busy[w_idx2]    <= 1'b1;
          r_op1_vld[w_idx2] <= i_dp_op1_vld_2 | w_byp12[DATA_W];
          r_op2_vld[w_idx2] <= i_dp_op2_vld_2 | w_byp22[DATA_W];
        end
      end
    end
  end

  // Payload storage carries no reset; outputs are masked while nothing is ready
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENT_NUM; i++) begin
      if (w_wk1[i]) r_op1[i] <= w_lk1[i][DATA_W-1:0];
      if (w_wk2[i]) r_op2[i] <= w_lk2[i][DATA_W-1:0];
    end
    if (w_wr1) begin
      r_op1[w_idx1]      <= w_op1_1;
      r_op2[w_idx1]      <= w_op2_1;
      r_rrftag[w_idx1]   <= i_dp_rrftag_1;
      r_signed1[w_idx1]  <= i_dp_signed1_1;
      r_signed2[w_idx1]  <= i_dp_signed2_1;
      r_sel_high[w_idx1] <= i_dp_sel_high_1;
    end
    if (w_wr2) begin
      r_op1[w_idx2]      <= w_op1_2;
      r_op2[w_idx2]      <= w_op2_2;
      r_rrftag[w_idx2]   <= i_dp_rrftag_2;
      r_signed1[w_idx2]  <= i_dp_signed1_2;
      r_signed2[w_idx2]  <= i_dp_signed2_2;
      r_sel_high[w_idx2] <= i_dp_sel_high_2;
    end
  end

  assign o_free_cnt    = (ENT_SEL + 1)'(ENT_NUM) - w_busy_cnt;
  assign o_busy_vec    = r_busy;
  assign o_rdy_vec     = w_rdy;
  assign o_ovf         = r_ovf;
  assign o_is_vld      = |w_rdy;
  assign o_is_signed1  = o_is_vld & r_signed1[w_sel_idx];
  assign o_is_signed2  = o_is_vld & r_signed2[w_sel_idx];
  assign o_is_sel_high = o_is_vld & r_sel_high[w_sel_idx];
  assign o_is_op1      = o_is_vld ? r_op1[w_sel_idx] : '0;
  assign o_is_op2      = o_is_vld ? r_op2[w_sel_idx] : '0;
  assign o_is_rrftag   = o_is_vld ? r_rrftag[w_sel_idx] : '0;

endmodule

// File: tb/tb_rs_mul_multi.sv
// Scoreboarded bench for rs_mul_multi: expected issues are queued by the stimulus
// and popped by a monitor on every issue handshake.
module tb_rs_mul_multi;
  logic        clk = 1'b0;
  logic        rst, i_flush, i_stall, i_is_rdy;
  logic        i_dp_vld_1, i_dp_signed1_1, i_dp_signed2_1, i_dp_sel_high_1, i_dp_op1_vld_1, i_dp_op2_vld_1;
  logic [31:0] i_dp_op1_1, i_dp_op2_1;
  logic [5:0]  i_dp_rrftag_1;
  logic        i_dp_vld_2, i_dp_signed1_2, i_dp_signed2_2, i_dp_sel_high_2, i_dp_op1_vld_2, i_dp_op2_vld_2;
  logic [31:0] i_dp_op1_2, i_dp_op2_2;
  logic [5:0]  i_dp_rrftag_2;
  logic [3:0]  i_wb_vld;
  logic [23:0] i_wb_tag;
  logic [127:0] i_wb_data;
  logic [2:0]  o_free_cnt;
  logic [3:0]  o_busy_vec, o_rdy_vec;
  logic        o_ovf, o_is_vld, o_is_signed1, o_is_signed2, o_is_sel_high;
  logic [31:0] o_is_op1, o_is_op2;
  logic [5:0]  o_is_rrftag;

  rs_mul_multi dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_stall(i_stall),
    .i_dp_vld_1(i_dp_vld_1), .i_dp_signed1_1(i_dp_signed1_1), .i_dp_signed2_1(i_dp_signed2_1),
    .i_dp_sel_high_1(i_dp_sel_high_1), .i_dp_op1_vld_1(i_dp_op1_vld_1), .i_dp_op2_vld_1(i_dp_op2_vld_1),
    .i_dp_op1_1(i_dp_op1_1), .i_dp_op2_1(i_dp_op2_1), .i_dp_rrftag_1(i_dp_rrftag_1),
    .i_dp_vld_2(i_dp_vld_2), .i_dp_signed1_2(i_dp_signed1_2), .i_dp_signed2_2(i_dp_signed2_2),
    .i_dp_sel_high_2(i_dp_sel_high_2), .i_dp_op1_vld_2(i_dp_op1_vld_2), .i_dp_op2_vld_2(i_dp_op2_vld_2),
    .i_dp_op1_2(i_dp_op1_2), .i_dp_op2_2(i_dp_op2_2), .i_dp_rrftag_2(i_dp_rrftag_2),
    .i_wb_vld(i_wb_vld), .i_wb_tag(i_wb_tag), .i_wb_data(i_wb_data),
    .o_free_cnt(o_free_cnt), .o_busy_vec(o_busy_vec), .o_rdy_vec(o_rdy_vec), .o_ovf(o_ovf),
    .o_is_vld(o_is_vld), .i_is_rdy(i_is_rdy), .o_is_signed1(o_is_signed1), .o_is_signed2(o_is_signed2),
    .o_is_sel_high(o_is_sel_high), .o_is_op1(o_is_op1), .o_is_op2(o_is_op2), .o_is_rrftag(o_is_rrftag)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b1;
  logic [127:0] exp_q[$];

  function automatic logic [127:0] pack(input logic s1, input logic s2, input logic h,
                                        input logic [5:0] tag, input logic [31:0] op1, input logic [31:0] op2);
    return {55'd0, s1, s2, h, tag, op1, op2};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && o_is_vld && i_is_rdy) begin
      if (exp_q.size() == 0) check("issue_unexpected", pack(o_is_signed1, o_is_signed2, o_is_sel_high, o_is_rrftag, o_is_op1, o_is_op2), '1);
      else check("issue", pack(o_is_signed1, o_is_signed2, o_is_sel_high, o_is_rrftag, o_is_op1, o_is_op2), exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_dp_vld_1 = 0; i_dp_signed1_1 = 0; i_dp_signed2_1 = 0; i_dp_sel_high_1 = 0;
    i_dp_op1_vld_1 = 0; i_dp_op2_vld_1 = 0; i_dp_op1_1 = 0; i_dp_op2_1 = 0; i_dp_rrftag_1 = 0;
    i_dp_vld_2 = 0; i_dp_signed1_2 = 0; i_dp_signed2_2 = 0; i_dp_sel_high_2 = 0;
    i_dp_op1_vld_2 = 0; i_dp_op2_vld_2 = 0; i_dp_op1_2 = 0; i_dp_op2_2 = 0; i_dp_rrftag_2 = 0;
    i_wb_vld = 0; i_wb_tag = 0; i_wb_data = 0;
  endtask

  task automatic dp1(input logic [5:0] tag, input logic v1, input logic [31:0] op1,
                     input logic v2, input logic [31:0] op2, input logic s1, input logic s2, input logic h);
    i_dp_vld_1 = 1; i_dp_rrftag_1 = tag; i_dp_op1_vld_1 = v1; i_dp_op1_1 = op1;
    i_dp_op2_vld_1 = v2; i_dp_op2_1 = op2; i_dp_signed1_1 = s1; i_dp_signed2_1 = s2; i_dp_sel_high_1 = h;
  endtask

  task automatic dp2(input logic [5:0] tag, input logic v1, input logic [31:0] op1,
                     input logic v2, input logic [31:0] op2, input logic s1, input logic s2, input logic h);
    i_dp_vld_2 = 1; i_dp_rrftag_2 = tag; i_dp_op1_vld_2 = v1; i_dp_op1_2 = op1;
    i_dp_op2_vld_2 = v2; i_dp_op2_2 = op2; i_dp_signed1_2 = s1; i_dp_signed2_2 = s2; i_dp_sel_high_2 = h;
  endtask

  task automatic bus(input int b, input logic [5:0] tag, input logic [31:0] data);
    i_wb_vld[b] = 1'b1;
    i_wb_tag[b*6 +: 6] = tag;
    i_wb_data[b*32 +: 32] = data;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (o_busy_vec != 0 && k < 12) begin tick(); k++; end
    check(name, o_busy_vec, 4'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; i_flush = 0; i_stall = 0; i_is_rdy = 0;
    clear_in();
    tick(); tick();
    check("rst_free_cnt", o_free_cnt, 3'd4);
    check("rst_busy", o_busy_vec, 4'h0);
    check("rst_rdy", o_rdy_vec, 4'h0);
    check("rst_ovf_isvld", {o_ovf, o_is_vld}, 2'b00);
    check("rst_is_data", {o_is_rrftag, o_is_op1, o_is_op2}, 70'd0);
    rst = 0;
    tick();

    // Two all-valid ops in one cycle, then a dispatch overlapping an issue
    i_is_rdy = 1;
    exp_q.push_back(pack(0, 0, 0, 6'd5, 32'd3, 32'd7));
    exp_q.push_back(pack(1, 0, 1, 6'd6, 32'd10, 32'd11));
    exp_q.push_back(pack(0, 1, 0, 6'd7, 32'd20, 32'd21));
    dp1(6'd5, 1, 32'd3, 1, 32'd7, 0, 0, 0);
    dp2(6'd6, 1, 32'd10, 1, 32'd11, 1, 0, 1);
    tick();
    clear_in();
    check("t1_free_after_dp", o_free_cnt, 3'd2);
    check("t1_first_sel", o_is_rrftag, 6'd5);
    dp1(6'd7, 1, 32'd20, 1, 32'd21, 0, 1, 0);
    tick();
    clear_in();
    check("t1_free_dp_and_issue", o_free_cnt, 3'd2);
    check("t1_busy", o_busy_vec, 4'h6);
    tick();
    check("t1_free_3", o_free_cnt, 3'd3);
    tick();
    check("t1_free_4", o_free_cnt, 3'd4);

    // Wakeup on bus 2 two cycles after dispatch
    dp1(6'd9, 0, 32'd12, 1, 32'd5, 0, 0, 0);
    tick();
    clear_in();
    check("t2_not_rdy", o_rdy_vec, 4'h0);
    tick();
    bus(2, 6'd12, 32'hFFFF_FFFE);
    #1;
    check("t2_no_same_cycle_issue", o_is_vld, 1'b0);
    exp_q.push_back(pack(0, 0, 0, 6'd9, 32'hFFFF_FFFE, 32'd5));
    tick();
    clear_in();
    check("t2_rdy_after_wb", o_rdy_vec, 4'h1);
    tick();
    check("t2_drained", o_free_cnt, 3'd4);

    // Dispatch-cycle bypass from bus 0
    dp1(6'd20, 0, 32'd3, 1, 32'd9, 1, 1, 0);
    bus(0, 6'd3, 32'h0000_1234);
    exp_q.push_back(pack(1, 1, 0, 6'd20, 32'h0000_1234, 32'd9));
    tick();
    clear_in();
    check("t3_bypass_rdy", o_rdy_vec, 4'h1);
    tick();

    // Fill, overflow, out-of-order readiness, oldest-first issue
    i_is_rdy = 0;
    dp1(6'd30, 0, 32'd40, 1, 32'd130, 0, 0, 0);
    dp2(6'd31, 0, 32'd41, 1, 32'd131, 0, 0, 0);
    tick();
    clear_in();
    dp1(6'd32, 0, 32'd42, 1, 32'd132, 0, 0, 0);
    dp2(6'd33, 0, 32'd43, 1, 32'd133, 0, 0, 0);
    tick();
    clear_in();
    check("t4_full_free", o_free_cnt, 3'd0);
    check("t4_full_busy", o_busy_vec, 4'hF);
    dp1(6'd34, 1, 32'd1, 1, 32'd2, 0, 0, 0);
    tick();
    clear_in();
    check("t4_ovf_pulse", o_ovf, 1'b1);
    check("t4_busy_kept", o_busy_vec, 4'hF);
    bus(1, 6'd43, 32'h33);
    tick();
    clear_in();
    check("t4_ovf_clear", o_ovf, 1'b0);
    check("t4_rdy_e3", o_rdy_vec, 4'h8);
    check("t4_sel_e3", {o_is_rrftag, o_is_op1}, {6'd33, 32'h33});
    bus(3, 6'd41, 32'h11);
    tick();
    clear_in();
    check("t4_rdy_e1_e3", o_rdy_vec, 4'hA);
    check("t4_sel_older_e1", o_is_rrftag, 6'd31);
    bus(0, 6'd40, 32'h10);
    bus(2, 6'd42, 32'h22);
    tick();
    clear_in();
    check("t4_rdy_all", o_rdy_vec, 4'hF);
    exp_q.push_back(pack(0, 0, 0, 6'd30, 32'h10, 32'd130));
    exp_q.push_back(pack(0, 0, 0, 6'd31, 32'h11, 32'd131));
    exp_q.push_back(pack(0, 0, 0, 6'd32, 32'h22, 32'd132));
    exp_q.push_back(pack(0, 0, 0, 6'd33, 32'h33, 32'd133));
    i_is_rdy = 1;
    drain("t4_drain");

    // Flush together with dispatch and an issue handshake
    i_is_rdy = 0;
    dp1(6'd50, 1, 32'd1, 1, 32'd1, 0, 0, 0);
    dp2(6'd51, 1, 32'd2, 1, 32'd2, 0, 0, 0);
    tick();
    clear_in();
    dp1(6'd52, 1, 32'd3, 1, 32'd3, 0, 0, 0);
    tick();
    clear_in();
    check("t5_busy3", o_busy_vec, 4'h7);
    mon_en = 0;
    i_flush = 1; i_is_rdy = 1;
    dp1(6'd53, 1, 32'd4, 1, 32'd4, 0, 0, 0);
    tick();
    clear_in();
    i_flush = 0; i_is_rdy = 0; mon_en = 1;
    check("t5_flush_busy", o_busy_vec, 4'h0);
    check("t5_flush_free", o_free_cnt, 3'd4);
    check("t5_flush_isvld_ovf", {o_is_vld, o_ovf}, 2'b00);

    // Reset mid-operation with a broadcast pending
    dp1(6'd60, 0, 32'd61, 1, 32'd0, 0, 0, 0);
    dp2(6'd62, 0, 32'd63, 1, 32'd0, 0, 0, 0);
    tick();
    clear_in();
    check("t6_busy2", o_busy_vec, 4'h3);
    rst = 1;
    bus(0, 6'd61, 32'hAA);
    tick();
    clear_in();
    rst = 0;
    check("t6_rst_free", o_free_cnt, 3'd4);
    check("t6_rst_vecs", {o_busy_vec, o_rdy_vec, o_ovf, o_is_vld}, 10'd0);
    check("t6_rst_is_data", {o_is_rrftag, o_is_op1, o_is_op2}, 70'd0);
    bus(0, 6'd61, 32'hAA);
    bus(1, 6'd63, 32'hBB);
    tick();
    clear_in();
    tick();
    check("t6_no_wakeup", {o_busy_vec, o_rdy_vec, o_is_vld}, 9'd0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rs_mul_multi.md
Name: rs_mul_multi

Overview:
- Parametrised multiplier reservation station; the successor to the fixed two-entry MUL RS.
- Sits between dispatch and the MUL execution unit. Holds up to ENT_NUM entries and accepts two instructions per cycle with internal free-slot allocation.
- Captures operands from WB_NUM result broadcast buses and issues the oldest ready entry to the multiplier over a valid/ready handshake.
- Supports a global flush.

Parameters:
- ENT_NUM, 4: number of entries (2..16).
- ENT_SEL, $clog2(ENT_NUM): entry index width.
- DATA_W, 32: operand width.
- TAG_W, 6: RRF tag width.
- WB_NUM, 4: number of result broadcast buses.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- i_flush  in  1  invalidate all entries.
- i_stall  in  1  dispatch stall; blocks all writes when high.
- i_dp_vld_k (k=1,2)  in  1  dispatch slot k valid.
- i_dp_signed1_k / i_dp_signed2_k / i_dp_sel_high_k  in  1 each  multiply mode bits.
- i_dp_op1_vld_k / i_dp_op2_vld_k  in  1 each  operand holds data (1) or a source tag (0).
- i_dp_op1_k / i_dp_op2_k  in  DATA_W  operand data, or tag in [TAG_W-1:0].
- i_dp_rrftag_k  in  TAG_W  destination tag.
- i_wb_vld  in  WB_NUM  broadcast valid per bus.
- i_wb_tag  in  WB_NUM*TAG_W  flattened tags; bus b occupies [b*TAG_W +: TAG_W].
- i_wb_data  in  WB_NUM*DATA_W  flattened results.
- o_free_cnt  out  ENT_SEL+1  number of non-busy entries (registered state).
- o_busy_vec  out  ENT_NUM  entry busy.
- o_rdy_vec  out  ENT_NUM  entry busy and both operands valid.
- o_ovf  out  1  dispatch dropped for lack of space (one-cycle pulse).
- o_is_vld  out  1  an entry is issuable.
- i_is_rdy  in  1  multiplier accepts the entry.
- o_is_signed1 / o_is_signed2 / o_is_sel_high  out  1 each  issued mode bits.
- o_is_op1 / o_is_op2  out  DATA_W  issued operands.
- o_is_rrftag  out  TAG_W  issued destination tag.

Behaviour:

Reset (rst=1 at an edge):
- All busy bits and operand-valid bits cleared; age matrix cleared.
- Outputs: o_free_cnt=ENT_NUM; o_busy_vec, o_rdy_vec, o_ovf and o_is_vld all 0; o_is_* data 0.
- Reset overrides flush, dispatch, wakeup and issue.

Flush (i_flush=1):
- Next edge clears every busy bit. Flush overrides dispatch, wakeup and issue in that cycle.
- o_is_vld may be high during the flush cycle, but a handshake in that cycle does not matter: the entry is cleared either way.

Allocation:
- Free set is taken from registered busy only. An entry freed by issue this cycle is not reusable until the next cycle.
- Slot 1 takes the lowest-index free entry. Slot 2 takes the next-lowest free entry, or the lowest if slot 1 is invalid.
- Write occurs when i_dp_vld_k && !i_stall && !i_flush.
- If a valid slot finds no free entry, that slot is dropped and o_ovf pulses 1 in the next cycle. The dispatcher must gate on o_free_cnt; a drop is a protocol error.

Wakeup:
- Each busy entry with an invalid operand compares its stored tag against every bus with i_wb_vld[b]=1. On a match it latches the data and sets the operand valid at the next edge.
- Dispatch-cycle bypass: a dispatched operand with vld=0 whose tag matches a live bus in the same cycle is written already valid, with the bus data.
- Multiple matching buses is illegal. If it occurs, the lowest b wins.

Issue:
- Candidates are the o_rdy_vec entries from registered state. Wakeup in cycle t makes an entry issuable at t+1, never t.
- Selection is oldest-first via an age matrix. age[i][j]=1 means i is older than j.
- On allocation of entry i: set row i to 0 and column i to 1 for all busy j. Slot 1 counts as older than slot 2 in the same cycle.
- o_is_* are combinational from the selected entry. o_is_vld = |o_rdy_vec.
- When o_is_vld && i_is_rdy at an edge, the selected entry's busy bit clears.
- If i_is_rdy=0, the selection may change only when an older entry becomes ready. Fields of an unchanged selection are stable.
- Exactly one issue per cycle maximum.

Counts:
- o_free_cnt = ENT_NUM - popcount(busy), registered-state derived.
- Simultaneous dispatch and issue in one cycle leaves free_cnt at old - dispatched + issued next cycle.

Test Plan:
- Reset, then dispatch two all-valid ops (tags 5, 6) in one cycle, with i_is_rdy=1 -> next cycle o_free_cnt=2; issue tag 5 (op1=3, op2=7), then tag 6 on the following cycle; free_cnt returns to 4.
- Dispatch tag 9 with op1 waiting on tag 12; two cycles later bus 2 broadcasts tag 12 with data 0xFFFF_FFFE -> o_rdy_vec bit set one cycle after the broadcast; issue shows o_is_op1=0xFFFF_FFFE.
- Dispatch an op waiting on tag 3 while tag 3 is on bus 0 in the same cycle -> entry is ready the next cycle with the bus data (bypass).
- Fill all 4 entries, hold i_is_rdy=0, make entries 3 then 1 ready, release i_is_rdy -> entries issue in allocation order, oldest first. A dispatch at free_cnt=0 -> o_ovf=1 for one cycle, and no entry is overwritten.
- Fill 3 entries, assert i_flush together with a dispatch and an issue handshake -> next cycle busy_vec=0, free_cnt=4, o_is_vld=0.
- Assert rst mid-operation with 2 busy entries and a broadcast pending -> next cycle all outputs at reset values; later broadcasts cause no wakeups.
